// File: rtl/dff_pkg.sv
// Shared types for the sequential shift register and its controller.
//   shreg_state_t : controller FSM state (IDLE, SHIFT)
//   shreg_dir_t   : shift direction latched at start (DIR_RIGHT toward bit 0, DIR_LEFT)
package dff_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} shreg_state_t;
    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} shreg_dir_t;

endpackage

// File: rtl/dff_shift_ctrl.sv
// Shift controller: FSM, step counter, amount saturation, busy/done and clr/set abort.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_clr, i_set           synchronous abort requests (force IDLE, clear counter)
//   i_load, i_start        commands, honoured only in IDLE (load wins)
//   i_dir, i_amt           direction and shift count, sampled at start
//   i_rot                  rotate select, sampled at start (DFF_ROTATE_EN only)
//   o_busy, o_done         in SHIFT / one-cycle completion pulse
//   o_load_en, o_step_en   datapath enables for this cycle
//   o_dir, o_rot           latched direction / rotate select for the datapath
// Config macro: DFF_ROTATE_EN adds i_rot/o_rot.
module dff_shift_ctrl
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_set,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_dir,
`ifdef DFF_ROTATE_EN
    input  logic             i_rot,
    output logic             o_rot,
`endif
    input  logic [CNT_W-1:0] i_amt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_load_en,
    output logic             o_step_en,
    output logic             o_dir
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    shreg_state_t     r_state, w_state_nxt;
    shreg_dir_t       r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] w_amt_sat;
    logic             w_abort;
`ifdef DFF_ROTATE_EN
    logic             r_rot, w_rot_nxt;
`endif

    assign w_amt_sat = (i_amt > MAX_CNT) ? MAX_CNT : i_amt;
    assign w_abort   = i_clr | i_set;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_dir   <= DIR_RIGHT;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef DFF_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
`ifdef DFF_ROTATE_EN
            r_rot   <= w_rot_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        o_load_en   = 1'b0;
        o_step_en   = 1'b0;
`ifdef DFF_ROTATE_EN
        w_rot_nxt   = r_rot;
`endif
        if (w_abort) begin
            // clr/set abandon any command in flight without a done pulse
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        o_load_en = 1'b1;
                    end else if (i_start) begin
                        w_dir_nxt = shreg_dir_t'(i_dir);
`ifdef DFF_ROTATE_EN
                        w_rot_nxt = i_rot;
`endif
                        if (w_amt_sat == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = SHIFT;
                            w_cnt_nxt   = w_amt_sat;
                        end
                    end
                end
                SHIFT: begin
                    o_step_en = 1'b1;
                    w_cnt_nxt = r_cnt - ONE;
                    // last step: done lands on the same edge as the final q
                    if (r_cnt == ONE) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == SHIFT);
    assign o_done = r_done;
    assign o_dir  = r_dir;
`ifdef DFF_ROTATE_EN
    assign o_rot  = r_rot;
`endif

endmodule

// File: rtl/dff_seq_shift_reg.sv
// WIDTH-bit register with synchronous clear/set, parallel load and a multi-cycle
// shift engine (one bit per clock for a commanded count).
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   clr, set          synchronous clear / set (clr wins), abort any shift
//   load, d           parallel load, IDLE only, wins over start
//   start, dir, amt   shift command (dir 0 = right, 1 = left; amt saturates at WIDTH)
//   sin               serial input at the vacated end
//   rot               rotate instead of inserting sin (DFF_ROTATE_EN only)
//   q, sout           register contents, last shifted-out bit
//   busy, done        shift in progress, one-cycle completion pulse
// Config macro: DFF_ROTATE_EN adds the rot port.
module dff_seq_shift_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = $clog2(WIDTH + 1),
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin,
`ifdef DFF_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             w_load_en, w_step_en, w_dir;
    logic             w_in_r, w_in_l;
`ifdef DFF_ROTATE_EN
    logic             w_rot;
`endif

    dff_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (clr),
        .i_set     (set),
        .i_load    (load),
        .i_start   (start),
        .i_dir     (dir),
`ifdef DFF_ROTATE_EN
        .i_rot     (rot),
        .o_rot     (w_rot),
`endif
        .i_amt     (amt),
        .o_busy    (busy),
        .o_done    (done),
        .o_load_en (w_load_en),
        .o_step_en (w_step_en),
        .o_dir     (w_dir)
    );

    // Bit entering the vacated end: the outgoing bit when rotating, else sin
`ifdef DFF_ROTATE_EN
    assign w_in_r = w_rot ? r_q[0]       : sin;
    assign w_in_l = w_rot ? r_q[WIDTH-1] : sin;
`else
    assign w_in_r = sin;
    assign w_in_l = sin;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
        end else if (clr) begin
            r_q    <= '0;
        end else if (set) begin
            r_q    <= SET_VAL;
        end else if (w_load_en) begin
            r_q    <= d;
        end else if (w_step_en) begin
            if (w_dir == DIR_LEFT) begin
                r_q    <= {r_q[WIDTH-2:0], w_in_l};
                r_sout <= r_q[WIDTH-1];
            end else begin
                r_q    <= {w_in_r, r_q[WIDTH-1:1]};
                r_sout <= r_q[0];
            end
        end
    end

    assign q    = r_q;
    assign sout = r_sout;

endmodule

// File: tb/tb_dff_seq_shift_reg.sv
module tb_dff_seq_shift_reg;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0, set = 1'b0, load = 1'b0, start = 1'b0, dir = 1'b0, sin = 1'b0;
    logic [7:0] d   = '0;
    logic [3:0] amt = '0;
`ifdef DFF_ROTATE_EN
    logic       rot = 1'b0;
`endif
    logic [7:0] q;
    logic       sout, busy, done;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q;
    logic       m_sout, m_busy, m_done, m_dir, m_rot;
    int         m_cnt;

    dff_seq_shift_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .set(set), .load(load), .d(d),
        .start(start), .dir(dir), .amt(amt), .sin(sin),
`ifdef DFF_ROTATE_EN
        .rot(rot),
`endif
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_dir = 1'b0; m_rot = 1'b0; m_cnt = 0;
    endtask

    // Advance model one clock using current inputs, push expectation, then
    // compare against the DUT just after the edge. Returns at the next negedge.
    task automatic tick();
        exp_t e;
        logic ob;
        logic rv;
        int   n;
        rv = 1'b0;
`ifdef DFF_ROTATE_EN
        rv = rot;
`endif
        if (clr) begin
            m_q = 8'h00; m_busy = 1'b0; m_cnt = 0; m_done = 1'b0;
        end else if (set) begin
            m_q = 8'hFF; m_busy = 1'b0; m_cnt = 0; m_done = 1'b0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (load) begin
                m_q = d;
            end else if (start) begin
                n = (int'(amt) > 8) ? 8 : int'(amt);
                m_dir = dir; m_rot = rv;
                if (n == 0) m_done = 1'b1;
                else begin m_busy = 1'b1; m_cnt = n; end
            end
        end else begin
            if (m_dir) begin
                ob  = m_q[7];
                m_q = {m_q[6:0], m_rot ? ob : sin};
            end else begin
                ob  = m_q[0];
                m_q = {m_rot ? ob : sin, m_q[7:1]};
            end
            m_sout = ob;
            m_cnt--;
            m_done = 1'b0;
            if (m_cnt == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end
        sb.push_back('{q: m_q, sout: m_sout, busy: m_busy, done: m_done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_q",    32'(q),    32'(e.q));
        chk("sb_sout", 32'(sout), 32'(e.sout));
        chk("sb_busy", 32'(busy), 32'(e.busy));
        chk("sb_done", 32'(done), 32'(e.done));
        @(negedge clk);
    endtask

    task automatic drv(input logic c, input logic s, input logic l, input logic [7:0] dd,
                       input logic st, input logic di, input logic [3:0] a, input logic si);
        clr = c; set = s; load = l; d = dd; start = st; dir = di; amt = a; sin = si;
        tick();
    endtask

    task automatic idle(input logic si);
        drv(0, 0, 0, 8'h00, 0, 0, 4'd0, si);
    endtask

    initial begin
        int bcnt;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_q",    32'(q),    32'h0);
        chk("rst_sout", 32'(sout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Load A5, shift right 3 with sin=1
        drv(0, 0, 1, 8'hA5, 0, 0, 4'd0, 0);
        drv(0, 0, 0, 8'h00, 1, 0, 4'd3, 1);
        chk("t2_q0", 32'(q), 32'hA5);
        chk("t2_b0", 32'(busy), 32'h1);
        idle(1); chk("t2_q1", 32'(q), 32'hD2); chk("t2_s1", 32'(sout), 32'h1);
        idle(1); chk("t2_q2", 32'(q), 32'hE9); chk("t2_s2", 32'(sout), 32'h0);
        idle(1); chk("t2_q3", 32'(q), 32'hF4); chk("t2_s3", 32'(sout), 32'h1);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_busy", 32'(busy), 32'h0);
        idle(0); chk("t2_done_off", 32'(done), 32'h0);

        // amt=0: immediate done, no busy
        drv(0, 0, 1, 8'h81, 0, 0, 4'd0, 0);
        drv(0, 0, 0, 8'h00, 1, 1, 4'd0, 0);
        chk("t3_q", 32'(q), 32'h81);
        chk("t3_busy", 32'(busy), 32'h0);
        chk("t3_done", 32'(done), 32'h1);
        idle(0); chk("t3_done_off", 32'(done), 32'h0);

        // Set aborts a shift; then amt=12 saturates to 8
        drv(0, 0, 0, 8'h00, 1, 0, 4'd5, 0);
        idle(0); idle(0);
        drv(0, 1, 0, 8'h00, 0, 0, 4'd0, 0);
        chk("t4_q", 32'(q), 32'hFF);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        bcnt = 0;
        drv(0, 0, 0, 8'h00, 1, 0, 4'd12, 0);
        if (busy) bcnt++;
        for (int i = 0; i < 8; i++) begin
            idle(0);
            if (busy) bcnt++;
        end
        chk("t4_busy_cycles", 32'(bcnt), 32'd8);
        chk("t4_sat_q", 32'(q), 32'h00);
        chk("t4_sat_done", 32'(done), 32'h1);
        chk("t4_sat_sout", 32'(sout), 32'h1);

        // clr+set+load together, then start+load together
        drv(1, 1, 1, 8'h5A, 0, 0, 4'd0, 0);
        chk("t5_clr_q", 32'(q), 32'h00);
        drv(0, 0, 1, 8'h3C, 1, 0, 4'd4, 1);
        chk("t5_ld_q", 32'(q), 32'h3C);
        chk("t5_ld_busy", 32'(busy), 32'h0);
        idle(1); chk("t5_ld_hold", 32'(q), 32'h3C);

`ifdef DFF_ROTATE_EN
        drv(0, 0, 1, 8'h96, 0, 0, 4'd0, 0);
        rot = 1'b1;
        drv(0, 0, 0, 8'h00, 1, 1, 4'd8, 0);
        rot = 1'b0;
        for (int i = 0; i < 8; i++) idle(0);
        chk("t6_rot8_q", 32'(q), 32'h96);
        chk("t6_rot8_done", 32'(done), 32'h1);
        drv(0, 0, 1, 8'h96, 0, 0, 4'd0, 0);
        rot = 1'b1;
        drv(0, 0, 0, 8'h00, 1, 1, 4'd1, 0);
        rot = 1'b0;
        idle(0);
        chk("t6_rot1_q", 32'(q), 32'h2D);
        chk("t6_rot1_done", 32'(done), 32'h1);
`endif

        // Asynchronous reset mid-shift
        drv(0, 0, 1, 8'hC3, 0, 0, 4'd0, 0);
        drv(0, 0, 0, 8'h00, 1, 1, 4'd6, 1);
        idle(1); idle(1);
        #2 rst = 1'b0;
        #1;
        chk("ar_q",    32'(q),    32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        chk("ar_sout", 32'(sout), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
`ifdef DFF_ROTATE_EN
            rot = 1'($urandom);
`endif
            drv(r == 4'd0, r == 4'd1, ($urandom % 5) == 0, 8'($urandom),
                ($urandom % 3) == 0, 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
